// File: rtl/uart_rx_parity_unit.sv
// rtl/uart_rx_parity_unit.sv - UART RX parity checker with runtime parity mode and saturating error counter
// Tracks one frame between start and the final parity strobe; result is a one-cycle parity_done pulse.
module uart_rx_parity_unit #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_strobe,
  input  logic                 dataline,
  input  logic [2:0]           parity_mode,
  input  logic                 clr_count,
  output logic                 busy,
  output logic                 parity_done,
  output logic                 parity_err,
  output logic                 parity_exp,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;
  typedef enum logic [2:0] {MODE_NONE, MODE_EVEN, MODE_ODD, MODE_MARK, MODE_SPACE} mode_e;

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic                 acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 exp_q, exp_d;
  logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;
  logic                 exp_bit;

  always_comb begin
    case (mode_q)
      MODE_EVEN: exp_bit = acc_q;
      MODE_ODD:  exp_bit = ~acc_q;
      MODE_MARK: exp_bit = 1'b1;
      default:   exp_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;
    exp_d    = exp_q;
    errcnt_d = errcnt_q;

    // start wins over a coincident strobe and restarts any frame in flight
    if (start) begin
      state_d = DATA;
      acc_d   = 1'b0;
      cnt_d   = '0;
      mode_d  = (parity_mode > 3'd4) ? MODE_NONE : mode_e'(parity_mode);
    end else begin
      case (state_q)
        DATA: begin
          if (bit_strobe) begin
            acc_d = acc_q ^ dataline;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              if (mode_q == MODE_NONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = 1'b0;
                exp_d   = 1'b0;
              end else begin
                state_d = PARITY;
              end
            end
          end
        end
        PARITY: begin
          if (bit_strobe) begin
            state_d = IDLE;
            done_d  = 1'b1;
            exp_d   = exp_bit;
            err_d   = (dataline != exp_bit);
          end
        end
        default: ;
      endcase
    end

    if (clr_count) begin
      errcnt_d = '0;
    end else if (done_d && err_d && !(&errcnt_q)) begin
      errcnt_d = errcnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_NONE;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      exp_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      exp_q    <= exp_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign parity_done = done_q;
  assign parity_err  = err_q;
  assign parity_exp  = exp_q;
  assign err_count   = errcnt_q;

endmodule

// File: tb/tb_uart_rx_parity_unit.sv
// tb/tb_uart_rx_parity_unit.sv - self-checking bench for uart_rx_parity_unit
// Two instances (DATA_W=8/ERR_CNT_W=2 and DATA_W=1/ERR_CNT_W=8) share one input stream and one frame-level model.
module tb_uart_rx_parity_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       strobe = 1'b0;
  logic       dline = 1'b0;
  logic [2:0] pmode = 3'd0;
  logic       clr = 1'b0;

  logic       a_busy, a_done, a_err, a_exp;
  logic [1:0] a_cnt;
  logic       b_busy, b_done, b_err, b_exp;
  logic [7:0] b_cnt;

  int ncmp = 0;
  int nfail = 0;

  int        m_active[2];
  int        m_nb[2];
  int        m_lmode[2];
  logic [15:0] m_word[2];
  int        m_done[2];
  int        m_err[2];
  int        m_exp[2];
  int        m_cnt[2];

  always #5 clk = ~clk;

  uart_rx_parity_unit #(.DATA_W(8), .ERR_CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .bit_strobe(strobe), .dataline(dline),
    .parity_mode(pmode), .clr_count(clr), .busy(a_busy), .parity_done(a_done),
    .parity_err(a_err), .parity_exp(a_exp), .err_count(a_cnt)
  );

  uart_rx_parity_unit #(.DATA_W(1), .ERR_CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start), .bit_strobe(strobe), .dataline(dline),
    .parity_mode(pmode), .clr_count(clr), .busy(b_busy), .parity_done(b_done),
    .parity_err(b_err), .parity_exp(b_exp), .err_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: collect data bits into a word, parity from the popcount of that word.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int dw;
      int cmax;
      int done_n;
      int e;
      dw   = (k == 0) ? 8 : 1;
      cmax = (k == 0) ? 3 : 255;
      if (rst) begin
        m_active[k] = 0; m_nb[k] = 0; m_lmode[k] = 0; m_word[k] = '0;
        m_done[k] = 0; m_err[k] = 0; m_exp[k] = 0; m_cnt[k] = 0;
      end else begin
        done_n = 0;
        if (start) begin
          m_active[k] = 1;
          m_nb[k]     = 0;
          m_word[k]   = '0;
          m_lmode[k]  = (pmode <= 3'd4) ? int'(pmode) : 0;
        end else if (m_active[k] != 0 && strobe) begin
          if (m_nb[k] < dw) begin
            m_word[k][m_nb[k]] = dline;
            m_nb[k]++;
            if (m_nb[k] == dw && m_lmode[k] == 0) begin
              m_active[k] = 0; done_n = 1; m_err[k] = 0; m_exp[k] = 0;
            end
          end else begin
            case (m_lmode[k])
              1: e = $countones(m_word[k]) % 2;
              2: e = 1 - ($countones(m_word[k]) % 2);
              3: e = 1;
              default: e = 0;
            endcase
            m_exp[k] = e;
            m_err[k] = (int'(dline) != e) ? 1 : 0;
            done_n = 1;
            m_active[k] = 0;
          end
        end
        m_done[k] = done_n;
        if (clr) m_cnt[k] = 0;
        else if (done_n != 0 && m_err[k] != 0 && m_cnt[k] < cmax) m_cnt[k]++;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_busy", 32'(a_busy), 32'(m_active[0]));
    chk("a_done", 32'(a_done), 32'(m_done[0]));
    chk("a_err",  32'(a_err),  32'(m_err[0]));
    chk("a_exp",  32'(a_exp),  32'(m_exp[0]));
    chk("a_cnt",  32'(a_cnt),  32'(m_cnt[0]));
    chk("b_busy", 32'(b_busy), 32'(m_active[1]));
    chk("b_done", 32'(b_done), 32'(m_done[1]));
    chk("b_err",  32'(b_err),  32'(m_err[1]));
    chk("b_exp",  32'(b_exp),  32'(m_exp[1]));
    chk("b_cnt",  32'(b_cnt),  32'(m_cnt[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    start = 1'b0;
    strobe = 1'b0;
    clr = 1'b0;
  endtask

  task automatic frame(input logic [2:0] m, input logic [15:0] data, input int n,
                       input bit send_par, input bit pbit, input bit clr_par);
    logic [15:0] w;
    w = data;
    pmode = m;
    start = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      tick();
      strobe = 1'b1;
      dline = w[i];
      tick();
    end
    if (send_par) begin
      tick();
      strobe = 1'b1;
      dline = pbit;
      clr = clr_par;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    rst = 1'b0;
    tick();

    frame(3'd1, 16'h00A5, 8, 1'b1, 1'b0, 1'b0);
    chk("even_done", 32'(a_done), 32'd1);
    chk("even_exp", 32'(a_exp), 32'd0);
    chk("even_err", 32'(a_err), 32'd0);
    chk("even_cnt", 32'(a_cnt), 32'd0);
    chk("even_busy", 32'(a_busy), 32'd0);
    tick();
    chk("done_width", 32'(a_done), 32'd0);

    frame(3'd1, 16'h00A5, 8, 1'b1, 1'b1, 1'b0);
    chk("even_bad_err", 32'(a_err), 32'd1);
    chk("even_bad_cnt", 32'(a_cnt), 32'd1);

    frame(3'd2, 16'h0001, 8, 1'b1, 1'b0, 1'b0);
    chk("odd_exp", 32'(a_exp), 32'd0);
    chk("odd_err", 32'(a_err), 32'd0);

    frame(3'd3, 16'h00FF, 8, 1'b1, 1'b0, 1'b0);
    chk("mark_exp", 32'(a_exp), 32'd1);
    chk("mark_err", 32'(a_err), 32'd1);

    frame(3'd4, 16'h0012, 8, 1'b1, 1'b1, 1'b0);
    chk("space_err", 32'(a_err), 32'd1);

    frame(3'd0, 16'h003C, 8, 1'b0, 1'b0, 1'b0);
    chk("none_done", 32'(a_done), 32'd1);
    chk("none_err", 32'(a_err), 32'd0);
    tick();
    strobe = 1'b1;
    dline = 1'b1;
    tick();
    chk("idle_strobe_done", 32'(a_done), 32'd0);
    tick();
    chk("idle_strobe_done2", 32'(a_done), 32'd0);

    frame(3'd6, 16'h003C, 8, 1'b0, 1'b0, 1'b0);
    chk("mode6_done", 32'(a_done), 32'd1);
    chk("mode6_err", 32'(a_err), 32'd0);

    frame(3'd1, 16'h000F, 4, 1'b0, 1'b0, 1'b0);
    frame(3'd1, 16'h0080, 8, 1'b1, 1'b1, 1'b0);
    chk("restart_done", 32'(a_done), 32'd1);
    chk("restart_err", 32'(a_err), 32'd0);

    frame(3'd1, 16'h0055, 8, 1'b0, 1'b0, 1'b0);
    chk("in_parity_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(a_busy), 32'd0);
    chk("rst_mid_done", 32'(a_done), 32'd0);
    chk("rst_mid_cnt", 32'(a_cnt), 32'd0);
    strobe = 1'b1;
    tick();
    tick();
    chk("rst_mid_nodone", 32'(a_done), 32'd0);

    for (int i = 0; i < 5; i++) begin
      frame(3'd3, 16'h0000, 8, 1'b1, 1'b0, 1'b0);
      chk("sat_cnt", 32'(a_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    frame(3'd3, 16'h0000, 8, 1'b1, 1'b0, 1'b1);
    chk("clr_prio_cnt", 32'(a_cnt), 32'd0);
    chk("clr_prio_err", 32'(a_err), 32'd1);

    pmode = 3'd1;
    start = 1'b1;
    tick();
    pmode = 3'd2;
    strobe = 1'b1;
    dline = 1'b1;
    tick();
    strobe = 1'b1;
    dline = 1'b1;
    tick();
    chk("dw1_done", 32'(b_done), 32'd1);
    chk("dw1_err", 32'(b_err), 32'd0);
    chk("dw1_exp", 32'(b_exp), 32'd1);

    start = 1'b1;
    strobe = 1'b1;
    tick();
    chk("start_wins_busy", 32'(b_busy), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom % 300) == 0;
      start  = ($urandom % 60) == 0;
      strobe = ($urandom % 3) == 0;
      dline  = 1'($urandom);
      pmode  = 3'($urandom);
      clr    = ($urandom % 80) == 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity_unit.md
Name: uart_rx_parity_unit

Overview:
Parametrised parity checker for the UART receive path, replacing the fixed single-bit XOR accumulator.
- Frames are delimited by the RX controller's `start` pulse and per-bit `bit_strobe` mid-bit sample pulses.
- Counts data bits and accumulates parity over DATA_W bits.
- Checks the received parity bit against a runtime-selected mode (none/even/odd/mark/space).
- Reports a one-cycle result pulse plus a saturating error counter.

Parameters:
DATA_W, 8, number of data bits per frame (legal 1..16)
ERR_CNT_W, 8, width of saturating parity-error counter (legal 1..32)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: start bit detected, begin new frame
bit_strobe  input  1  one-cycle pulse: dataline valid for current data/parity bit
dataline  input  1  sampled serial RX bit
parity_mode  input  3  0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 treated as none
clr_count  input  1  synchronous clear of err_count
busy  output  1  high while a frame is being tracked (state != IDLE)
parity_done  output  1  one-cycle pulse: frame parity result valid
parity_err  output  1  result of last checked frame, held until next parity_done
parity_exp  output  1  expected parity bit of last frame, held until next parity_done
err_count  output  ERR_CNT_W  saturating count of frames with parity_err=1

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; accumulator, bit counter, latched mode, all outputs = 0.
  - Applies mid-frame: the frame is abandoned with no parity_done.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - On start: latch parity_mode, clear accumulator (acc=0) and bit counter (cnt=0), go to DATA.
  - bit_strobe in IDLE is ignored.
- DATA, on bit_strobe:
  - acc <= acc ^ dataline; cnt <= cnt+1.
  - On the strobe where cnt==DATA_W-1:
    - Latched mode none: go to IDLE and assert parity_done next cycle with parity_err=0, parity_exp=0; err_count unchanged.
    - Otherwise: go to PARITY.
- PARITY:
  - Expected bit E: even=acc, odd=~acc, mark=1, space=0.
  - On bit_strobe: parity_exp<=E, parity_err<=(dataline!=E), parity_done<=1, go to IDLE.
- Latency: parity_done is asserted on the cycle after the final bit_strobe of the frame and is exactly one cycle wide.
- busy:
  - Goes high the cycle after start is accepted.
  - Goes low in the same cycle parity_done asserts.
- start while busy (DATA or PARITY): restart the frame — relatch mode, acc=0, cnt=0, stay/go DATA. No parity_done for the aborted frame.
- start and bit_strobe in the same cycle: start wins; the strobe is ignored.
- parity_mode changes mid-frame have no effect; only the value latched at start is used.
- err_count:
  - Increments by 1 when parity_done && parity_err is registered.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - clr_count sets it to 0 and has priority over a simultaneous increment.
  - rst has priority over all.
- parity_err and parity_exp change only on parity_done cycles (or reset).

Test Plan:
- DATA_W=8, even mode, data 0xA5, parity bit 0 -> parity_done one cycle after parity strobe, parity_exp=0, parity_err=0, err_count=0; parity bit 1 instead -> parity_err=1, err_count=1.
- Odd mode, data 0x01, parity bit 0 -> parity_exp=0, parity_err=0. Mark mode, data 0xFF, parity bit 0 -> parity_exp=1, parity_err=1. Space mode, parity bit 1 -> parity_err=1.
- Mode none (and mode 6), data 0x3C -> parity_done the cycle after the 8th data strobe, parity_err=0; a following extra strobe in IDLE produces no output.
- start after 4 data strobes, then full new frame 0x80 even, parity 1 -> exactly one parity_done, parity_err=0. rst asserted in PARITY -> busy=0, no parity_done, err_count=0.
- ERR_CNT_W=2: 5 consecutive error frames -> err_count 1,2,3,3,3. clr_count on the same cycle as an error parity_done -> err_count=0, parity_err=1.
- DATA_W=1, even, data 1, parity 1 -> parity_err=0. Change parity_mode from even to odd mid-frame -> result still computed as even.
